// File: rtl/divider_pkg.sv
// Shared ALU definitions: datapath width, divider FSM encoding and flag slot indices.
// The multiplier uses the same flag indices.
package divider_pkg;

   localparam int unsigned WIDTH = 32;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StFix  = 2'd2
   } state_e;

   localparam int unsigned FlagNeg  = 3;
   localparam int unsigned FlagZero = 2;
   localparam int unsigned FlagDiv0 = 1;
   localparam int unsigned FlagOvf  = 0;

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit and
// trial-subtract the divisor magnitude.
module divider_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic             din,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH:0]   rem_next,
   output logic             qbit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   always_comb begin
      shifted = {rem, din};
      diff    = shifted - {2'b00, dvs};
      // A set top bit means the trial subtraction borrowed, so restore.
      qbit     = ~diff[WIDTH+1];
      rem_next = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
   end

endmodule

// File: rtl/divider.sv
// Sequential signed divider: 32 restoring steps on magnitudes, then a sign fix-up
// cycle. Fixed latency of 34 cycles from an accepted start to done.
module divider #(
   parameter int unsigned WIDTH = divider_pkg::WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] In1,
   input  logic signed [WIDTH-1:0] In2,
   input  logic                    S,
   output logic                    busy,
   output logic                    done,
   output logic signed [WIDTH-1:0] Out,
   output logic signed [WIDTH-1:0] Rem,
   output logic [3:0]              Flags
);

   import divider_pkg::*;

   localparam int unsigned CntW = $clog2(WIDTH);

   state_e state_q, state_d;

   logic [CntW-1:0]  cnt_q;
   logic [WIDTH:0]   prem_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] in1_q;
   logic             sgn1_q, sgn2_q, s_q;
   logic [WIDTH-1:0] out_q, rem_q;
   logic [3:0]       flags_q;
   logic             done_q;

   logic             load, step, fix;
   logic [WIDTH:0]   prem_next;
   logic             qbit;
   logic [WIDTH-1:0] quot_fix, rem_fix;
   logic [3:0]       flags_fix;
   logic             div0, ovf;

   divider_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem      (prem_q),
      .din      (dvd_q[WIDTH-1]),
      .dvs      (dvs_q),
      .rem_next (prem_next),
      .qbit     (qbit)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StCalc;
         StCalc:  if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q != StIdle);
      load = (state_q == StIdle) && start;
      step = (state_q == StCalc);
      fix  = (state_q == StFix);
      done = done_q;
   end

   // Sign fix-up; the quotient magnitude sits in dvd_q once all bits are shifted in.
   always_comb begin
      quot_fix = (sgn1_q ^ sgn2_q) ? -dvd_q : dvd_q;
      rem_fix  = sgn1_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
      div0     = (dvs_q == '0);
      ovf      = sgn1_q && sgn2_q && (dvs_q == WIDTH'(1)) &&
                 (in1_q == {1'b1, {(WIDTH-1){1'b0}}});
      if (div0) begin
         quot_fix = '1;
         rem_fix  = in1_q;
      end
      flags_fix = '0;
      if (s_q) begin
         flags_fix[FlagNeg]  = quot_fix[WIDTH-1];
         flags_fix[FlagZero] = (quot_fix == '0);
         flags_fix[FlagDiv0] = div0;
         flags_fix[FlagOvf]  = ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         prem_q  <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         in1_q   <= '0;
         sgn1_q  <= 1'b0;
         sgn2_q  <= 1'b0;
         s_q     <= 1'b0;
         out_q   <= '0;
         rem_q   <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= fix;
         if (load) begin
            cnt_q  <= '0;
            prem_q <= '0;
            in1_q  <= In1;
            sgn1_q <= In1[WIDTH-1];
            sgn2_q <= In2[WIDTH-1];
            s_q    <= S;
            // Negating the most negative value yields 2^(WIDTH-1) as an unsigned magnitude.
            dvd_q  <= In1[WIDTH-1] ? -In1 : In1;
            dvs_q  <= In2[WIDTH-1] ? -In2 : In2;
         end else if (step) begin
            cnt_q  <= cnt_q + CntW'(1);
            prem_q <= prem_next;
            dvd_q  <= {dvd_q[WIDTH-2:0], qbit};
         end else if (fix) begin
            out_q   <= quot_fix;
            rem_q   <= rem_fix;
            flags_q <= flags_fix;
         end
      end
   end

   assign Out   = out_q;
   assign Rem   = rem_q;
   assign Flags = flags_q;

endmodule
